// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e    : operation encodings presented on the op port
//   state_e : sequencer states (IDLE -> CALC -> FIX -> IDLE)
//   is_div / is_signed : small decode helpers for op_e values
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    function automatic logic is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step (purely combinational).
//   rem_in   : partial remainder, always below the divisor
//   quo_in   : dividend/quotient shift register; its MSB is the next dividend bit
//   divisor  : divisor magnitude
//   rem_out  : partial remainder after this step
//   quo_out  : quo_in shifted left with the new quotient bit in the LSB
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           q_bit;

    // The shifted remainder needs WIDTH+1 bits; a borrow out of the
    // subtraction shows up in diff[WIDTH] and means "restore".
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], q_bit};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers, one bit per clock.
//   clk, rst      : clock, synchronous active-high reset
//   start, op     : request and operation (MULT/MULTU/DIV/DIVU), sampled when idle
//   a, b          : multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we  : MTHI/MTLO writes of wdata, honoured only when idle without start
//   busy, done    : operation in progress / one-cycle completion pulse
//   div_by_zero   : sticky until the next accepted start
//   hi, lo        : product upper/lower half, or remainder/quotient
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state, state_nxt;
    op_e                op_q;
    logic [WIDTH-1:0]   acc;     // product upper half / partial remainder
    logic [WIDTH-1:0]   mq;      // multiplier shifting out / dividend->quotient
    logic [WIDTH-1:0]   opb_q;   // multiplicand or divisor magnitude
    logic [CW-1:0]      count;
    logic               neg_lo;  // negate product or quotient
    logic               neg_hi;  // negate remainder

    // Request decode
    op_e                op_in;
    logic               in_neg_a, in_neg_b, in_div_zero, accept;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign op_in       = op_e'(op);
    assign in_neg_a    = is_signed(op_in) & a[WIDTH-1];
    assign in_neg_b    = is_signed(op_in) & b[WIDTH-1];
    // The most negative value maps onto itself, which is also its correct
    // unsigned magnitude.
    assign mag_a       = in_neg_a ? -a : a;
    assign mag_b       = in_neg_b ? -b : b;
    assign in_div_zero = is_div(op_in) && (b == '0);
    assign accept      = (state == S_IDLE) && start;

    // Datapath steps
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem, div_quo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign mul_sum = {1'b0, acc} + {1'b0, (mq[0] ? opb_q : '0)};

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in  (acc),
        .quo_in  (mq),
        .divisor (opb_q),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    assign prod_fix = neg_lo ? -{acc, mq} : {acc, mq};
    assign quo_fix  = neg_lo ? -mq : mq;
    assign rem_fix  = neg_hi ? -acc : acc;

    assign busy = (state != S_IDLE);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = in_div_zero ? S_FIX : S_CALC;
            S_CALC: if (count == CW'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_MULT;
            acc         <= '0;
            mq          <= '0;
            opb_q       <= '0;
            count       <= '0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q        <= op_in;
                        acc         <= '0;
                        // Divide-by-zero keeps the raw dividend for HI.
                        mq          <= in_div_zero ? a : mag_a;
                        opb_q       <= mag_b;
                        count       <= '0;
                        neg_lo      <= in_neg_a ^ in_neg_b;
                        neg_hi      <= in_neg_a;
                        div_by_zero <= in_div_zero;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_CALC: begin
                    count <= count + 1'b1;
                    if (is_div(op_q)) begin
                        acc <= div_rem;
                        mq  <= div_quo;
                    end else begin
                        // Shift {sum, multiplier} right; the sum's LSB becomes
                        // the next settled product bit.
                        acc <= mul_sum[WIDTH:1];
                        mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (div_by_zero) begin
                        hi <= mq;
                        lo <= '1;
                    end else if (is_div(op_q)) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request; returns just after the sampling edge with start cleared.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
        start = 1'b1; op = o; a = xa; b = xb;
        tick();
        start = 1'b0;
    endtask

    // Waits for done while checking busy; c0 = edges already elapsed since start.
    task automatic wait_done(input string tag, input int c0, input int lat,
                             input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        int c = c0;
        while (!done && c <= lat + 2) begin
            check({tag, "_busy"}, busy, 1);
            tick();
            c++;
        end
        check({tag, "_done_cycle"}, c, lat);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        check({tag, "_dz"}, div_by_zero, edz);
    endtask

    initial begin
        int seen_done;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        // 1: MULTU max*max, then done must drop after one cycle
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 0, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        tick();
        check("done_one_cycle", done, 0);

        // 2: MULT -3*7
        issue(2'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done("mult_neg", 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

        // 3: DIV -7/2, then DIVU 7/2 issued in the done cycle
        issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done("div_neg", 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(2'd3, 32'h0000_0007, 32'h0000_0002);
        wait_done("divu_chain", 0, 33, 32'h0000_0001, 32'h0000_0003, 1'b0);

        // 4: signed overflow min / -1
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 0, 33, 32'h0000_0000, 32'h8000_0000, 1'b0);

        // min*min exact
        issue(2'd0, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_minmin", 0, 33, 32'h4000_0000, 32'h0000_0000, 1'b0);

        // 5: divide by zero, then MULTU clears the flag
        issue(2'd3, 32'h1234_5678, 32'h0000_0000);
        wait_done("divu_zero", 0, 1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        tick();
        check("dz_sticky", div_by_zero, 1);
        issue(2'd1, 32'h0000_0009, 32'h0000_000B);
        check("dz_cleared", div_by_zero, 0);
        wait_done("multu_after_dz", 0, 33, 32'h0000_0000, 32'h0000_0063, 1'b0);

        // 6a: reset at cycle 10 of a MULT aborts without done
        issue(2'd0, 32'h0000_1234, 32'h0000_5678);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        seen_done = 0;
        repeat (30) begin
            if (done) seen_done = 1;
            tick();
        end
        check("abort_no_done", seen_done, 0);

        // 6b: start while busy is ignored
        issue(2'd1, 32'h0000_0003, 32'h0000_0005);
        repeat (4) begin
            check("ign_busy", busy, 1);
            tick();
        end
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        wait_done("ignored_start", 5, 33, 32'h0000_0000, 32'h0000_000F, 1'b0);

        // 6c: MTLO while idle; both writes together
        lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        tick();
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'hA5A5_A5A5);
        check("mtlo_hi_kept", hi, 32'h0000_0000);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_0F0F;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthilo_hi", hi, 32'h5A5A_0F0F);
        check("mthilo_lo", lo, 32'h5A5A_0F0F);
        lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        tick();
        lo_we = 1'b0;

        // 6d: lo_we together with start is dropped
        lo_we = 1'b1; wdata = 32'h1234_5678;
        issue(2'd1, 32'h0000_0002, 32'h0000_0003);
        lo_we = 1'b0;
        check("mtlo_dropped", lo, 32'hA5A5_A5A5);
        wait_done("multu_small", 0, 33, 32'h0000_0000, 32'h0000_0006, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
